// File: rtl/axi_qenc_multi.sv
// Multi-channel quadrature encoder counter with an AXI4-Lite register slave.
// Per channel: 2-flop synchronisers, glitch filters, x4 decoder, index latch and sticky flags.
module axi_qenc_multi #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 4,
  parameter int ADDR_W   = 7
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  input  logic [N_CH-1:0]   enc_a,
  input  logic [N_CH-1:0]   enc_b,
  input  logic [N_CH-1:0]   enc_z,
  output logic              irq
);
  localparam int NP   = 3 * N_CH;   // pin vector layout: {z, b, a}
  localparam int CH_W = ADDR_W - 4;

  logic [NP-1:0]    sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [3:0]       fcnt_q [NP];
  logic [3:0]       fcnt_d [NP];
  logic [CNT_W-1:0] count_q [N_CH];
  logic [CNT_W-1:0] count_d [N_CH];
  logic [CNT_W-1:0] zlatch_q [N_CH];
  logic [CNT_W-1:0] zlatch_d [N_CH];
  logic [3:0]       ctrl_q [N_CH];
  logic [3:0]       ctrl_d [N_CH];
  logic [N_CH-1:0]  err_q, err_d, zseen_q, zseen_d, dir_q, dir_d;
  logic             irq_q, irq_d;
  logic             awready_q, awready_d, bvalid_q, bvalid_d;
  logic             arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]      rdata_q, rdata_d, rd_word;
  logic             wr_hs, rd_hs, wr_ok, rd_ok;
  logic [CH_W-1:0]  wch, rch;
  logic [1:0]       wreg, rreg;
  logic             unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic ch_ok(input logic [CH_W-1:0] c);
    return 32'(c) < 32'(N_CH);
  endfunction

  function automatic logic [CNT_W-1:0] merge_wr(input logic [CNT_W-1:0] old,
                                                input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] full;
    full = 32'(old);
    for (int b = 0; b < 4; b++) if (strb[b]) full[8*b +: 8] = data[8*b +: 8];
    return full[CNT_W-1:0];
  endfunction

  // Synchronisers and glitch filters: output follows input after FILT_LEN equal samples.
  always_comb begin
    sync1_d     = {enc_z, enc_b, enc_a};
    sync2_d     = sync1_q;
    filt_prev_d = filt_q;
    filt_d      = filt_q;
    for (int p = 0; p < NP; p++) begin
      fcnt_d[p] = '0;
      if (sync2_q[p] != filt_q[p]) begin
        if (fcnt_q[p] == 4'(FILT_LEN - 1)) filt_d[p] = sync2_q[p];
        else                               fcnt_d[p] = fcnt_q[p] + 4'd1;
      end
    end
  end

  // Handshake rule: a transfer happens on the clock edge where VALID and READY are both high;
  // READY pulses for one cycle, responses hold VALID until the master's READY.
  always_comb begin
    wch       = S_AXI_AWADDR[ADDR_W-1:4];
    wreg      = S_AXI_AWADDR[3:2];
    rch       = S_AXI_ARADDR[ADDR_W-1:4];
    rreg      = S_AXI_ARADDR[3:2];
    wr_ok     = ch_ok(wch);
    rd_ok     = ch_ok(rch);
    wr_hs     = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    rd_hs     = arready_q & S_AXI_ARVALID;
    awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & ~bvalid_q;
    arready_d = S_AXI_ARVALID & ~arready_q & ~rvalid_q;
    bvalid_d  = bvalid_q ? ~S_AXI_BREADY : wr_hs;
    rvalid_d  = rvalid_q ? ~S_AXI_RREADY : rd_hs;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rd_word   = 32'h0;
    for (int i = 0; i < N_CH; i++) begin
      if (rch == CH_W'(i)) begin
        case (rreg)
          2'd0:    rd_word = 32'(count_q[i]);
          2'd1:    rd_word = 32'(zlatch_q[i]);
          2'd2:    rd_word = {28'h0, ctrl_q[i]};
          default: rd_word = {29'h0, dir_q[i], zseen_q[i], err_q[i]};
        endcase
      end
    end
    if (wr_hs) bresp_d = wr_ok ? 2'b00 : 2'b10;
    if (rd_hs) begin
      rresp_d = rd_ok ? 2'b00 : 2'b10;
      rdata_d = rd_ok ? rd_word : 32'h0;
    end
  end

  // Per-channel decode: AXI COUNT write beats Z clear, which beats a decoder step.
  always_comb begin
    logic a_ch, b_ch, z_rise, en, up, sel, w1c_ok;
    irq_d = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      count_d[i]  = count_q[i];
      zlatch_d[i] = zlatch_q[i];
      ctrl_d[i]   = ctrl_q[i];
      dir_d[i]    = dir_q[i];
      a_ch   = filt_q[i] ^ filt_prev_q[i];
      b_ch   = filt_q[N_CH+i] ^ filt_prev_q[N_CH+i];
      z_rise = filt_q[2*N_CH+i] & ~filt_prev_q[2*N_CH+i];
      en     = ctrl_q[i][0];
      up     = filt_q[i] ^ filt_prev_q[N_CH+i] ^ ctrl_q[i][1];
      sel    = wr_hs & wr_ok & (wch == CH_W'(i));
      w1c_ok = sel & (wreg == 2'd3) & S_AXI_WSTRB[0];
      if (sel && wreg == 2'd0) begin
        count_d[i] = merge_wr(count_q[i], S_AXI_WDATA, S_AXI_WSTRB);
      end else if (en && z_rise && ctrl_q[i][2]) begin
        count_d[i] = '0;
      end else if (en && (a_ch ^ b_ch)) begin
        count_d[i] = up ? count_q[i] + 1'b1 : count_q[i] - 1'b1;
        dir_d[i]   = up;
      end
      if (en && z_rise) zlatch_d[i] = count_q[i];
      if (sel && wreg == 2'd2 && S_AXI_WSTRB[0]) ctrl_d[i] = S_AXI_WDATA[3:0];
      err_d[i]   = (err_q[i] & ~(w1c_ok & S_AXI_WDATA[0])) | (en & a_ch & b_ch);
      zseen_d[i] = (zseen_q[i] & ~(w1c_ok & S_AXI_WDATA[1])) | (en & z_rise);
      irq_d      = irq_d | (ctrl_q[i][3] & (err_q[i] | zseen_q[i]));
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      for (int p = 0; p < NP; p++) fcnt_q[p] <= '0;
      for (int i = 0; i < N_CH; i++) begin
        count_q[i]  <= '0;
        zlatch_q[i] <= '0;
        ctrl_q[i]   <= '0;
      end
      err_q     <= '0;
      zseen_q   <= '0;
      dir_q     <= '0;
      irq_q     <= 1'b0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      for (int p = 0; p < NP; p++) fcnt_q[p] <= fcnt_d[p];
      for (int i = 0; i < N_CH; i++) begin
        count_q[i]  <= count_d[i];
        zlatch_q[i] <= zlatch_d[i];
        ctrl_q[i]   <= ctrl_d[i];
      end
      err_q     <= err_d;
      zseen_q   <= zseen_d;
      dir_q     <= dir_d;
      irq_q     <= irq_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign irq           = irq_q;
endmodule
